stopwatch_timer_core: RTL and testbench

- Parametrised N-digit BCD stopwatch/countdown-timer counter. Next generation of the board's 4-digit stopwatch.
- Runs entirely on the system clock. An internal prescaler produces a tick enable, so there are no derived or gated clocks.
- Outputs packed BCD digits to the hex-to-7-segment decoders and the display multiplexer FSM.
- Adds an explicit run/pause/done state machine, edge-detected start/stop, a synchronous clear, and optional minutes:seconds radix.

---
 rtl/stopwatch_timer_core.sv | 156 +++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer_core.sv
// N-digit BCD stopwatch / countdown timer with an internal prescaler tick and a run/pause/done FSM.
// Optional macro MMSS_RADIX_EN makes odd-index digits radix 6 (mm:ss display).
module stopwatch_timer_core #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                toggle,
  input  logic                clear,
  input  logic [1:0]          mode,
  input  logic [4*DIGITS-1:0] preload,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                done,
  output logic                tick
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  function automatic logic [W-1:0] max_pattern();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef MMSS_RADIX_EN
      r[4*i +: 4] = (i % 2 == 1) ? 4'd5 : 4'd9;
`else
      r[4*i +: 4] = 4'd9;
`endif
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_PAT = max_pattern();

  // Each nibble is clamped to its own digit maximum, so the radix-6 clamp comes for free.
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > MAX_PAT[4*i +: 4]) ? MAX_PAT[4*i +: 4] : v[4*i +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (!down) begin
          if (v[4*i +: 4] >= MAX_PAT[4*i +: 4]) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = v[4*i +: 4] + 4'd1; carry = 1'b0; end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = MAX_PAT[4*i +: 4];
          else begin r[4*i +: 4] = v[4*i +: 4] - 4'd1; carry = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [W-1:0]  start_val, terminal, stepped, digits_next;
  logic          toggle_d, start_edge, count_down, step_en;
  logic          tick_next, running_next, done_next;

  assign start_edge = toggle & ~toggle_d;
  assign terminal   = count_down ? '0 : MAX_PAT;
  assign stepped    = bcd_step(digits, count_down);

  always_comb begin
    start_val = '0;
    case (mode)
      2'b01, 2'b10: start_val = sanitise(preload);
      2'b11:        start_val = MAX_PAT;
      default:      start_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    presc_next = presc;
    step_en    = 1'b0;
    tick_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      presc_next = '0;
    end else begin
      case (state)
        IDLE: begin
          presc_next = '0;
          if (start_edge) state_next = RUN;
        end
        RUN: begin
          if (start_edge) begin
            state_next = PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_next = '0;
            tick_next  = 1'b1;
            // Already at the terminal value: finish without stepping past it.
            if (digits == terminal) state_next = DONE;
            else begin
              step_en = 1'b1;
              if (stepped == terminal) state_next = DONE;
            end
          end else begin
            presc_next = presc + PW'(1);
          end
        end
        PAUSE:   if (start_edge) state_next = RUN;
        DONE:    if (start_edge) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running_next = (state_next == RUN);
    done_next    = (state_next == DONE);
    digits_next  = digits;
    if (state_next == IDLE) digits_next = start_val;
    else if (step_en)       digits_next = stepped;
  end

  // Registered datapath and outputs; direction is latched only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      toggle_d   <= 1'b0;
      count_down <= 1'b0;
      digits     <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      presc    <= presc_next;
      toggle_d <= toggle;
      if (state == IDLE) count_down <= mode[1];
      digits   <= digits_next;
      running  <= running_next;
      done     <= done_next;
      tick     <= tick_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Self-checking bench for stopwatch_timer_core (DIGITS=4, TICK_DIV=4): vector table,
// tick scoreboard and hand-written pause / clear / done / reset sequences.
module tb_stopwatch_timer_core;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int W        = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         toggle = 1'b0;
  logic         clear = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] preload = '0;
  logic [W-1:0] digits;
  logic         running, done, tick;

  stopwatch_timer_core #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .toggle(toggle), .clear(clear), .mode(mode),
    .preload(preload), .digits(digits), .running(running), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] preload;
    int           nticks;
    logic [W-1:0] exp_start;
    logic [W-1:0] exp_final;
    logic         exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] b);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Every tick pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset && tick) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick actual=tick digits=%h required=no tick", digits);
      end else begin
        chk("tick_digits", digits, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_toggle();
    toggle = 1'b1;
    step();
    toggle = 1'b0;
  endtask

  task automatic load(input logic [1:0] m, input logic [W-1:0] p);
    clear = 1'b1; mode = m; preload = p;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] cur, term;
    int           n;

    vecs[0] = '{2'b00, 16'h1234, 3, 16'h0000, 16'h0003, 1'b0};
    vecs[1] = '{2'b01, 16'h0098, 2, 16'h0098, 16'h0100, 1'b0};
    vecs[2] = '{2'b10, 16'h0002, 2, 16'h0002, 16'h0000, 1'b1};
    vecs[3] = '{2'b01, 16'h0A9F, 0, 16'h0999, 16'h0999, 1'b0};
    vecs[4] = '{2'b11, 16'h1234, 2, 16'h9999, 16'h9997, 1'b0};
    vecs[5] = '{2'b01, 16'h9998, 1, 16'h9998, 16'h9999, 1'b1};
    vecs[6] = '{2'b10, 16'h0000, 1, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{2'b10, 16'h1000, 1, 16'h1000, 16'h0999, 1'b0};

    repeat (2) step();
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", running, 0);
    chk("reset_done", done, 0);
    chk("reset_tick", tick, 0);
    reset = 1'b1;
    step();
    chk("idle_after_reset", digits, 16'h0000);

`ifndef MMSS_RADIX_EN
    for (int v = 0; v < 8; v++) begin
      load(vecs[v].mode, vecs[v].preload);
      chk("idle_start", digits, vecs[v].exp_start);
      chk("idle_running", running, 0);
      if (vecs[v].nticks > 0) begin
        cur  = vecs[v].exp_start;
        term = vecs[v].mode[1] ? 16'h0000 : 16'h9999;
        for (int k = 0; k < vecs[v].nticks; k++) begin
          if (cur != term)
            cur = int2bcd(vecs[v].mode[1] ? bcd2int(cur) - 1 : bcd2int(cur) + 1);
          sb_q.push_back(cur);
        end
        pulse_toggle();
        wait_drain("vec_ticks", 4 * vecs[v].nticks + 8);
        chk("vec_final", digits, vecs[v].exp_final);
        chk("vec_done", done, vecs[v].exp_done);
        chk("vec_running", running, !vecs[v].exp_done);
      end
    end

    // Pause holds digits and prescaler; resume continues from the held phase.
    load(2'b01, 16'h0098);
    sb_q.push_back(16'h0099);
    pulse_toggle();
    wait_drain("pause_first_tick", 12);
    step();
    pulse_toggle();
    chk("pause_running", running, 0);
    repeat (20) step();
    chk("pause_digits", digits, 16'h0099);
    chk("pause_done", done, 0);
    sb_q.push_back(16'h0100);
    pulse_toggle();
    chk("resume_running", running, 1);
    n = 0;
    while (!tick && n < 10) begin
      step();
      n++;
    end
    chk("resume_latency", n, 3);
    chk("resume_digits", digits, 16'h0100);

    // DONE freezes, then a start edge goes back to IDLE and reloads.
    load(2'b10, 16'h0002);
    sb_q.push_back(16'h0001);
    sb_q.push_back(16'h0000);
    pulse_toggle();
    wait_drain("done_ticks", 16);
    repeat (6) step();
    chk("done_hold_digits", digits, 16'h0000);
    chk("done_hold_done", done, 1);
    chk("done_hold_running", running, 0);
    pulse_toggle();
    chk("done_reload_digits", digits, 16'h0002);
    chk("done_reload_done", done, 0);

    // Clear, start edge and tick all on one edge: clear wins.
    load(2'b00, 16'h0000);
    sb_q.push_back(16'h0001);
    pulse_toggle();
    wait_drain("clear_first_tick", 12);
    repeat (3) step();
    clear = 1'b1;
    toggle = 1'b1;
    step();
    clear = 1'b0;
    toggle = 1'b0;
    chk("clear_tick", tick, 0);
    chk("clear_digits", digits, 16'h0000);
    chk("clear_running", running, 0);
    repeat (8) step();
    chk("clear_stays_idle", running, 0);

    // Asynchronous reset between clock edges.
    load(2'b01, 16'h0098);
    sb_q.push_back(16'h0099);
    pulse_toggle();
    wait_drain("reset_first_tick", 12);
    step();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_digits", digits, 16'h0000);
    chk("async_reset_running", running, 0);
    chk("async_reset_done", done, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset_idle", digits, 16'h0098);
`else
    load(2'b01, 16'h0A9F);
    chk("mmss_clamp", digits, 16'h0959);
    load(2'b01, 16'h0058);
    chk("mmss_start", digits, 16'h0058);
    sb_q.push_back(16'h0059);
    sb_q.push_back(16'h0100);
    pulse_toggle();
    wait_drain("mmss_up", 16);
    chk("mmss_up_final", digits, 16'h0100);
    load(2'b10, 16'h0100);
    sb_q.push_back(16'h0059);
    pulse_toggle();
    wait_drain("mmss_down", 12);
    chk("mmss_down_final", digits, 16'h0059);
    load(2'b11, 16'h0000);
    chk("mmss_max", digits, 16'h5959);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
